// File: rtl/pio_button_poller.sv
// rtl/pio_button_poller.sv - Avalon-MM poller and debouncer for a button PIO
//
// Purpose:
//   Periodically reads the data register of a button PIO, debounces every
//   bit independently and reports the debounced state, one-cycle press and
//   release pulses, and a sticky interrupt, so no CPU polling is needed.
//
// Ports:
//   clk_i           system clock
//   reset_n_i       asynchronous active-low reset
//   address_o       Avalon address to the PIO (always 0, data register)
//   read_o          Avalon read strobe (one cycle per poll)
//   readdata_i      PIO readdata, valid the cycle after the read strobe
//   button_state_o  debounced state, 1 = pressed
//   press_o         one-cycle pulse per bit on an accepted press
//   release_o       one-cycle pulse per bit on an accepted release
//   irq_o           sticky interrupt, set by any press pulse
//   irq_ack_i       clears irq_o (a simultaneous press wins)

module pio_button_poller #(
  parameter int WIDTH          = 3,
  parameter int POLL_CYCLES    = 50000,
  parameter int DEBOUNCE_COUNT = 8,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  output logic [1:0]       address_o,
  output logic             read_o,
  input  logic [31:0]      readdata_i,
  output logic [WIDTH-1:0] button_state_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic             irq_o,
  input  logic             irq_ack_i
);

  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [7:0]       CNT_LAST   = 8'(DEBOUNCE_COUNT - 1);
  localparam logic [WIDTH-1:0] INV_MASK   = {WIDTH{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EVAL = 2'd3
  } state_e;

  state_e           state_q;
  logic             read_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] raw_sample;

  logic [TW-1:0]    timer_q, timer_d;
  logic             timer_tc;

  logic [WIDTH-1:0] btn_q, btn_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];
  logic             irq_q, irq_d;

  // Bits above WIDTH are don't-care from the PIO.
  logic             unused_readdata;
  assign unused_readdata = ^readdata_i;

  // Normalise so that 1 always means pressed.
  assign raw_sample = readdata_i[WIDTH-1:0] ^ INV_MASK;

  // Free-running poll timer; never stalls so the period is exact.
  assign timer_tc = (timer_q == TIMER_LAST);
  assign timer_d  = timer_tc ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Poll sequencer: IDLE -> REQ -> WAIT -> EVAL -> IDLE.
  // read_q is registered so it is high exactly while in REQ.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      read_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (timer_tc) begin
            state_q <= ST_REQ;
            read_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
          read_q  <= 1'b0;
        end
        ST_WAIT: begin
          // PIO readdata is registered, so it is valid in this cycle.
          sample_q <= raw_sample;
          state_q  <= ST_EVAL;
        end
        ST_EVAL: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-bit debounce: a change is accepted only after DEBOUNCE_COUNT
  // consecutive polls disagree with the current state. Pulses default to 0
  // so they last exactly one cycle after EVAL.
  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (state_q == ST_EVAL) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sample_q[i] == btn_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == CNT_LAST) begin
          btn_d[i]     = ~btn_q[i];
          cnt_d[i]     = 8'd0;
          press_d[i]   = ~btn_q[i];
          release_d[i] = btn_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // irq is set from the visible press pulse, so an ack in the pulse cycle
  // still leaves irq high (set wins).
  always_comb begin
    irq_d = irq_q;
    if (|press_q) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      irq_q     <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign address_o      = 2'b00;
  assign read_o         = read_q;
  assign button_state_o = btn_q;
  assign press_o        = press_q;
  assign release_o      = release_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_pio_button_poller.sv
// tb/tb_pio_button_poller.sv - self-checking bench for pio_button_poller
module tb_pio_button_poller;

  localparam int W    = 3;
  localparam int POLL = 4;
  localparam int DEB  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata = '0;
  logic [W-1:0] button_state, press, release_p;
  logic        irq;
  logic        irq_ack = 1'b0;
  logic [W-1:0] in_port = 3'b111;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_read = -1;

  // Behavioural reference: per-bit window of samples since the last change.
  bit           hist [W][$];
  logic [W-1:0] exp_state = '0;
  logic [W-1:0] exp_press = '0;
  logic [W-1:0] exp_release = '0;
  logic         exp_irq = 1'b0;

  pio_button_poller #(
    .WIDTH(W), .POLL_CYCLES(POLL), .DEBOUNCE_COUNT(DEB), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .address_o(address), .read_o(read),
    .readdata_i(readdata), .button_state_o(button_state), .press_o(press),
    .release_o(release_p), .irq_o(irq), .irq_ack_i(irq_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model: registered readdata with random junk in the upper bits.
  always @(posedge clk) begin
    if (read) readdata <= {29'($urandom()), in_port};
  end

  task automatic model_reset();
    for (int i = 0; i < W; i++) hist[i].delete();
    exp_state = '0; exp_press = '0; exp_release = '0; exp_irq = 1'b0;
  endtask

  // A change is accepted when the last DEB samples since the previous
  // change all disagree with the current state.
  task automatic model_poll(input logic [W-1:0] raw);
    bit s, all_diff;
    exp_press = '0; exp_release = '0;
    for (int i = 0; i < W; i++) begin
      s = ~raw[i];
      hist[i].push_back(s);
      if (hist[i].size() > DEB) void'(hist[i].pop_front());
      all_diff = (hist[i].size() == DEB);
      foreach (hist[i][k]) if (hist[i][k] == exp_state[i]) all_diff = 0;
      if (all_diff) begin
        exp_state[i] = ~exp_state[i];
        if (exp_state[i]) exp_press[i] = 1'b1; else exp_release[i] = 1'b1;
        hist[i].delete();
      end
    end
  endtask

  // One full poll: present raw, find REQ, check pulse cycle and cycle after.
  task automatic poll(input logic [W-1:0] raw, input logic ack);
    int waited;
    in_port = raw;
    waited = 0;
    while (read !== 1'b1 && waited < 12) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL poll_timeout: read=%b required 1 within 12 cycles", read);
      return;
    end
    if (last_read >= 0) begin
      checks++;
      if (cyc - last_read !== POLL) begin
        errors++;
        $display("FAIL poll_period: got %0d cycles, required %0d", cyc - last_read, POLL);
      end
    end
    last_read = cyc;
    model_poll(raw);
    repeat (3) @(negedge clk);
    checks++;
    if (button_state !== exp_state || press !== exp_press || release_p !== exp_release) begin
      errors++;
      $display("FAIL pulse_cycle: state=%b press=%b release=%b required state=%b press=%b release=%b",
               button_state, press, release_p, exp_state, exp_press, exp_release);
    end
    checks++;
    if (irq !== exp_irq) begin
      errors++;
      $display("FAIL irq_pre: irq=%b required %b", irq, exp_irq);
    end
    irq_ack = ack;
    @(negedge clk);
    irq_ack = 1'b0;
    exp_irq = (|exp_press) ? 1'b1 : (ack ? 1'b0 : exp_irq);
    checks++;
    if (irq !== exp_irq || press !== '0 || release_p !== '0) begin
      errors++;
      $display("FAIL after_pulse: irq=%b press=%b release=%b required irq=%b press=000 release=000",
               irq, press, release_p, exp_irq);
    end
  endtask

  task automatic wait_first_read();
    int waited;
    waited = 0;
    while (read !== 1'b1 && waited < 12) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (waited !== POLL) begin
      errors++;
      $display("FAIL first_read: read after %0d cycles, required %0d", waited, POLL);
    end
    last_read = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if (read !== 1'b0 || address !== 2'b00 || button_state !== '0 ||
        press !== '0 || release_p !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: read=%b addr=%b state=%b press=%b release=%b irq=%b required all 0",
               read, address, button_state, press, release_p, irq);
    end
    model_reset();
    reset_n = 1'b1;
    wait_first_read();
    repeat (3) poll(3'b111, 1'b0);
  endtask

  task automatic test_press();
    repeat (3) poll(3'b110, 1'b0);
    poll(3'b110, 1'b0);
    checks++;
    if (irq !== 1'b1 || button_state !== 3'b001) begin
      errors++;
      $display("FAIL press_hold: irq=%b state=%b required irq=1 state=001", irq, button_state);
    end
  endtask

  task automatic test_release();
    repeat (3) poll(3'b111, 1'b0);
    checks++;
    if (irq !== 1'b1 || button_state !== 3'b000) begin
      errors++;
      $display("FAIL release_irq: irq=%b state=%b required irq=1 state=000", irq, button_state);
    end
    poll(3'b111, 1'b1);
  endtask

  task automatic test_glitch();
    repeat (3) begin
      poll(3'b110, 1'b0);
      poll(3'b111, 1'b0);
    end
    poll(3'b110, 1'b0);
    poll(3'b110, 1'b0);
    checks++;
    if (button_state !== 3'b000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch: state=%b irq=%b required state=000 irq=0", button_state, irq);
    end
    repeat (3) poll(3'b111, 1'b0);
  endtask

  task automatic test_ack_collision();
    repeat (3) poll(3'b101, 1'b0);
    repeat (2) poll(3'b001, 1'b0);
    poll(3'b001, 1'b1);
    checks++;
    if (irq !== 1'b1 || button_state !== 3'b110) begin
      errors++;
      $display("FAIL ack_collision: irq=%b state=%b required irq=1 state=110", irq, button_state);
    end
  endtask

  task automatic test_reset_midpoll();
    poll(3'b001, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || button_state !== '0 || irq !== 1'b0 ||
        press !== '0 || release_p !== '0) begin
      errors++;
      $display("FAIL reset_midpoll: read=%b state=%b irq=%b press=%b release=%b required all 0",
               read, button_state, irq, press, release_p);
    end
    model_reset();
    in_port = 3'b111;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_first_read();
    repeat (2) poll(3'b110, 1'b0);
    poll(3'b111, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] raw;
    int hold;
    for (int n = 0; n < 60; n++) begin
      raw  = W'($urandom_range(0, 7));
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) poll(raw, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_ack_collision();
    test_reset_midpoll();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
